// File: rtl/reg_write_pkg.sv
// Shared types and constants for the register write controller.
// The optional trailing checksum is enabled by defining REG_WRITE_CTRL_CSUM_EN.
package reg_write_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CSUM,
    COMMIT
  } state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Wide enough for up to 8 data bytes (DATA_WIDTH = 64).
  localparam int CNT_W = 4;

  function automatic int byte_count(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/reg_write_shifter.sv
// Data word assembly register with a running XOR of every byte it sees.
// The XOR output is consumed only when REG_WRITE_CTRL_CSUM_EN is defined.
module reg_write_shifter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  acc,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic [7:0]            csum
);

  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] word_shift;

  // MSB-first: earlier bytes move up as each new byte enters at the bottom.
  assign word_shift = (word_q << 8) | DATA_WIDTH'(byte_in);

  // Value the word will hold after this edge, so a commit taken on the
  // last data byte already sees that byte.
  assign word_next  = load ? word_shift : word_q;

  // NOTE: the assembly register takes the synchronous reset too, so a frame
  // interrupted by reset leaves no stale partial word behind.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      word_q <= '0;
      csum   <= '0;
    end else if (clear) begin
      word_q <= '0;
      csum   <= '0;
    end else if (load) begin
      word_q <= word_shift;
      csum   <= csum ^ byte_in;
    end else if (acc) begin
      csum   <= csum ^ byte_in;
    end
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Framed byte-stream to one-hot clock-enable write controller.
// Define REG_WRITE_CTRL_CSUM_EN to require a trailing XOR checksum byte.
module reg_write_ctrl
  import reg_write_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [7:0]            IN_BYTE,
  output logic [NUM_REGS-1:0]   CE_OUT,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  ERR_OUT,
  output logic                  BUSY
);

  localparam int              NUM_BYTES = byte_count(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      byte_cnt;
  logic [7:0]            addr_q;
  logic                  in_ready_q;
  logic                  fire;
  logic                  sh_clear, sh_load, sh_acc;
  logic [DATA_WIDTH-1:0] word_next;
  logic [7:0]            csum_acc;
  logic                  enter_commit;
  logic                  addr_ok;
  logic                  csum_ok;
  logic                  commit_ok;

  assign fire     = IN_VALID && in_ready_q;
  assign IN_READY = in_ready_q;
  assign BUSY     = (state != IDLE);

  // NOTE: every signal driven here gets its default before the case, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fire && IN_BYTE == HEADER_BYTE) state_next = ADDR;
      ADDR:   if (fire) state_next = DATA;
      DATA: begin
        if (fire && byte_cnt == LAST_CNT) begin
`ifdef REG_WRITE_CTRL_CSUM_EN
          state_next = CSUM;
`else
          state_next = COMMIT;
`endif
        end
      end
      CSUM:   if (fire) state_next = COMMIT;
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The address byte only feeds the checksum; data bytes shift into the word.
  assign sh_clear = (state == IDLE) && fire && (IN_BYTE == HEADER_BYTE);
  assign sh_acc   = (state == ADDR) && fire;
  assign sh_load  = (state == DATA) && fire;

  reg_write_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .clear     (sh_clear),
    .load      (sh_load),
    .acc       (sh_acc),
    .byte_in   (IN_BYTE),
    .word_next (word_next),
    .csum      (csum_acc)
  );

  assign enter_commit = (state != COMMIT) && (state_next == COMMIT);
  assign addr_ok      = {24'd0, addr_q} < 32'(NUM_REGS);

`ifdef REG_WRITE_CTRL_CSUM_EN
  // Entry into COMMIT comes from CSUM, so IN_BYTE is the checksum byte.
  assign csum_ok = (IN_BYTE == csum_acc);
`else
  logic unused_csum;
  assign unused_csum = ^csum_acc;
  assign csum_ok     = 1'b1;
`endif

  assign commit_ok = addr_ok && csum_ok;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= IDLE;
      byte_cnt <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_next;
      if (state == ADDR && fire) begin
        addr_q   <= IN_BYTE;
        byte_cnt <= '0;
      end else if (sh_load) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  // Strobes are decided on the edge that accepts the last frame byte, so
  // they are visible exactly during the COMMIT cycle.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      in_ready_q <= 1'b0;
      CE_OUT     <= '0;
      ERR_OUT    <= 1'b0;
      DATA_OUT   <= '0;
    end else begin
      in_ready_q <= (state_next != COMMIT);
      CE_OUT     <= '0;
      ERR_OUT    <= 1'b0;
      if (enter_commit) begin
        if (commit_ok) begin
          CE_OUT   <= NUM_REGS'(1'b1) << addr_q;
          DATA_OUT <= word_next;
        end else begin
          ERR_OUT  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Scoreboard bench for reg_write_ctrl at DATA_WIDTH=16, NUM_REGS=4.
// Follows REG_WRITE_CTRL_CSUM_EN to decide whether frames carry a checksum.
module tb_reg_write_ctrl;

  localparam int DW = 16;
  localparam int NR = 4;

  typedef struct packed {
    logic [NR-1:0] ce;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [7:0]    IN_BYTE = 8'h00;
  logic [NR-1:0] CE_OUT;
  logic [DW-1:0] DATA_OUT;
  logic          ERR_OUT;
  logic          BUSY;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  reg_write_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_BYTE  (IN_BYTE),
    .CE_OUT   (CE_OUT),
    .DATA_OUT (DATA_OUT),
    .ERR_OUT  (ERR_OUT),
    .BUSY     (BUSY)
  );

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every strobe or error pulse must match the next queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RSTN && (CE_OUT != '0 || ERR_OUT)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", {CE_OUT, ERR_OUT}, 0);
        end else begin
          e = sb_q.pop_front();
          check("commit_ce",   CE_OUT,   e.ce);
          check("commit_err",  ERR_OUT,  e.err);
          check("commit_data", DATA_OUT, e.data);
        end
      end
    end
  end

  // Called at a falling edge; returns at a falling edge once the byte moved.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    bit ok;
    stalls   = 0;
    IN_VALID = 1'b1;
    IN_BYTE  = b;
    forever begin
      ok = IN_READY;
      @(negedge CLK);
      if (ok) break;
      stalls++;
      if (stalls > 20) begin
        check("byte_accept_timeout", stalls, 0);
        break;
      end
    end
  endtask

  task automatic idle(input int cycles);
    IN_VALID = 1'b0;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [15:0] d,
                            input logic [7:0] csum, input logic [NR-1:0] e_ce,
                            input logic e_err, input logic [DW-1:0] e_data,
                            output int hdr_stalls);
    int s;
    send_byte(8'hA5, hdr_stalls);
    send_byte(addr, s);
    send_byte(d[15:8], s);
`ifdef REG_WRITE_CTRL_CSUM_EN
    send_byte(d[7:0], s);
    sb_q.push_back('{ce: e_ce, err: e_err, data: e_data});
    send_byte(csum, s);
`else
    if (csum === 8'hxx) $display("note: checksum byte unused");
    sb_q.push_back('{ce: e_ce, err: e_err, data: e_data});
    send_byte(d[7:0], s);
`endif
  endtask

  initial begin
    int s;

    // Reset held with a header on the bus.
    IN_VALID = 1'b1;
    IN_BYTE  = 8'hA5;
    repeat (3) @(negedge CLK);
    check("rst_ce",    CE_OUT,   0);
    check("rst_data",  DATA_OUT, 0);
    check("rst_err",   ERR_OUT,  0);
    check("rst_busy",  BUSY,     0);
    check("rst_ready", IN_READY, 0);
    RSTN = 1'b1;
    @(negedge CLK);
    check("ready_after_release", IN_READY, 1);
    check("busy_after_release",  BUSY,     0);
    idle(1);

    // Valid write to register 2.
    send_frame(8'h02, 16'h1234, 8'h24, 4'b0100, 1'b0, 16'h1234, s);
    idle(2);

    // Out-of-range address: error, data held.
    send_frame(8'h07, 16'hABCD, 8'h61, 4'b0000, 1'b1, 16'h1234, s);
    idle(2);

`ifdef REG_WRITE_CTRL_CSUM_EN
    // Checksum mismatch (correct value would be 0x00).
    send_frame(8'h01, 16'h0001, 8'hFF, 4'b0000, 1'b1, 16'h1234, s);
    idle(2);
`endif

    // Junk before a header is silently dropped.
    send_byte(8'h00, s);
    send_byte(8'hFF, s);
    send_byte(8'h5A, s);
    check("busy_after_junk", BUSY, 0);
    send_frame(8'h00, 16'hBEEF, 8'h51, 4'b0001, 1'b0, 16'hBEEF, s);
    idle(2);

    // Back-to-back with IN_VALID held high: one bubble before frame two.
    send_frame(8'h01, 16'h1122, 8'h32, 4'b0010, 1'b0, 16'h1122, s);
    check("b2b_first_hdr_stall", s, 0);
    send_frame(8'h03, 16'h3344, 8'h74, 4'b1000, 1'b0, 16'h3344, s);
    check("b2b_second_hdr_stall", s, 1);
    idle(2);

    // Reset after header and address.
    send_byte(8'hA5, s);
    send_byte(8'h01, s);
    check("busy_mid_frame", BUSY, 1);
    RSTN     = 1'b0;
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    check("midrst_ce",    CE_OUT,   0);
    check("midrst_err",   ERR_OUT,  0);
    check("midrst_data",  DATA_OUT, 0);
    check("midrst_busy",  BUSY,     0);
    check("midrst_ready", IN_READY, 0);
    RSTN = 1'b1;
    @(negedge CLK);
    check("midrst_ready_release", IN_READY, 1);
    send_frame(8'h01, 16'h55AA, 8'hFE, 4'b0010, 1'b0, 16'h55AA, s);
    idle(4);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
